// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx line, 8 data bits LSB first, optional parity, 1 stop bit.
// Received bytes sit in a single-entry valid/ready register; error conditions are one-cycle pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int unsigned   CW      = $clog2(CLKS_PER_BIT);
  localparam int unsigned   HALF    = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  function automatic logic calc_parity(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_t        state_r;
  logic [1:0]    sync_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [7:0]    shift_r;
  logic          par_r;
  logic [7:0]    data_r;
  logic          valid_r;
  logic          frame_err_r;
  logic          parity_err_r;
  logic          overrun_r;
  logic          rx_s;
  logic          parity_bad_s;

  assign rx_s         = sync_r[1];
  assign parity_bad_s = (PARITY_EN != 1'b0) && (par_r != calc_parity(shift_r, PARITY_ODD));

  // Synchroniser, bit-timing FSM and output register; idle-high line resets the flops to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      sync_r       <= 2'b11;
      cnt_r        <= '0;
      idx_r        <= 3'd0;
      shift_r      <= 8'h00;
      par_r        <= 1'b0;
      data_r       <= 8'h00;
      valid_r      <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      sync_r       <= {sync_r[0], rx_i};
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
      if (valid_r && rx_ready_i) begin
        valid_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (!rx_s) begin
            state_r <= START;
            cnt_r   <= '0;
          end
        end
        // Half-bit sample rejects glitches and aligns data samples to mid-bit.
        START: begin
          if (cnt_r == HALF_M1) begin
            cnt_r <= '0;
            idx_r <= 3'd0;
            state_r <= rx_s ? IDLE : DATA;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_r == LAST) begin
            cnt_r   <= '0;
            shift_r <= {rx_s, shift_r[7:1]};
            idx_r   <= idx_r + 3'd1;
            if (idx_r == 3'd7) begin
              state_r <= (PARITY_EN != 1'b0) ? PARITY : STOP;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        PARITY: begin
          if (cnt_r == LAST) begin
            cnt_r   <= '0;
            par_r   <= rx_s;
            state_r <= STOP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        // Framing error outranks parity error; a good byte loads unless the register is still full.
        STOP: begin
          if (cnt_r == LAST) begin
            cnt_r <= '0;
            if (!rx_s) begin
              frame_err_r <= 1'b1;
              state_r     <= WAIT_IDLE;
            end else if (parity_bad_s) begin
              parity_err_r <= 1'b1;
              state_r      <= IDLE;
            end else begin
              if (!valid_r || rx_ready_i) begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
              end else begin
                overrun_r <= 1'b1;
              end
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign rx_data_o    = data_r;
  assign rx_valid_o   = valid_r;
  assign frame_err_o  = frame_err_r;
  assign parity_err_o = parity_err_r;
  assign overrun_o    = overrun_r;
  assign busy_o       = (state_r != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: instance 0 is 8N1, instance 1 is 8E1, both at 16 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rxl;
  logic [1:0] rdy;
  logic [1:0] vld;
  logic [1:0] fe;
  logic [1:0] pe;
  logic [1:0] ov;
  logic [1:0] bsy;
  logic [7:0] dout [2];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  int         acc    [2] = '{0, 0};
  int         vcyc   [2] = '{0, 0};
  int         nfe    [2] = '{0, 0};
  int         npe    [2] = '{0, 0};
  int         nov    [2] = '{0, 0};
  int         t_rise [2] = '{0, 0};
  logic [7:0] last   [2] = '{8'h00, 8'h00};
  logic [1:0] vprev = 2'b00;

  typedef struct {
    int         d;
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         e_acc;
    int         e_fe;
    int         e_pe;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_8n1 (
    .clk(clk), .rst(rst), .rx_i(rxl[0]), .rx_data_o(dout[0]), .rx_valid_o(vld[0]),
    .rx_ready_i(rdy[0]), .frame_err_o(fe[0]), .parity_err_o(pe[0]), .overrun_o(ov[0]),
    .busy_o(bsy[0])
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_8e1 (
    .clk(clk), .rst(rst), .rx_i(rxl[1]), .rx_data_o(dout[1]), .rx_valid_o(vld[1]),
    .rx_ready_i(rdy[1]), .frame_err_o(fe[1]), .parity_err_o(pe[1]), .overrun_o(ov[1]),
    .busy_o(bsy[1])
  );

  // Output monitor: counts transfers, valid cycles and error pulses per instance.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (vld[d] && rdy[d]) begin
        acc[d]  <= acc[d] + 1;
        last[d] <= dout[d];
      end
      if (vld[d] && !vprev[d]) t_rise[d] <= cyc;
      vcyc[d] <= vcyc[d] + int'(vld[d]);
      nfe[d]  <= nfe[d] + int'(fe[d]);
      npe[d]  <= npe[d] + int'(pe[d]);
      nov[d]  <= nov[d] + int'(ov[d]);
    end
    vprev <= vld;
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive_bit(input int d, input logic v);
    rxl[d] = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input int d, input logic [7:0] b, input logic par, input logic stop);
    drive_bit(d, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d, b[i]);
    if (d == 1) drive_bit(d, par);
    drive_bit(d, stop);
  endtask

  task automatic idle(input int d, input int n);
    rxl[d] = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  int s_acc, s_fe, s_pe, s_ov, s_vc, t_fall;

  initial begin
    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 1, 0, 0};
    vecs[1] = '{0, 8'h00, 1'b0, 1'b1, 1, 0, 0};
    vecs[2] = '{0, 8'hFF, 1'b0, 1'b1, 1, 0, 0};
    vecs[3] = '{0, 8'h3C, 1'b0, 1'b0, 0, 1, 0};
    vecs[4] = '{1, 8'h07, 1'b0, 1'b1, 0, 0, 1};
    vecs[5] = '{1, 8'h07, 1'b1, 1'b1, 1, 0, 0};
    vecs[6] = '{1, 8'h00, 1'b0, 1'b1, 1, 0, 0};
    vecs[7] = '{1, 8'hFF, 1'b0, 1'b1, 1, 0, 0};
    vecs[8] = '{1, 8'h01, 1'b0, 1'b1, 0, 0, 1};
    vecs[9] = '{1, 8'h80, 1'b0, 1'b0, 0, 1, 0};

    rst = 1'b1;
    rxl = 2'b11;
    rdy = 2'b11;
    repeat (3) @(negedge clk);
    check("reset valid", int'(vld), 0);
    check("reset busy", int'(bsy), 0);
    check("reset errors", int'({fe, pe, ov}), 0);
    check("reset data", int'(dout[0]), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 latency: valid rises 155 cycles after rx falls and lasts one cycle with ready high.
    s_vc = vcyc[0]; s_fe = nfe[0]; s_ov = nov[0];
    t_fall = cyc;
    send(0, 8'hA5, 1'b0, 1'b1);
    idle(0, 48);
    check("latency", t_rise[0] - t_fall, 155);
    check("latency data", int'(last[0]), 8'hA5);
    check("valid width", vcyc[0] - s_vc, 1);
    check("latency errors", (nfe[0] - s_fe) + (nov[0] - s_ov), 0);

    // Glitch shorter than half a bit.
    s_acc = acc[0]; s_fe = nfe[0];
    rxl[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch busy high", int'(bsy[0]), 1);
    rxl[0] = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch busy low", int'(bsy[0]), 0);
    check("glitch no byte", acc[0] - s_acc, 0);
    check("glitch no error", nfe[0] - s_fe, 0);

    for (int i = 0; i < 10; i++) begin
      s_acc = acc[vecs[i].d]; s_fe = nfe[vecs[i].d]; s_pe = npe[vecs[i].d];
      send(vecs[i].d, vecs[i].data, vecs[i].par, vecs[i].stop);
      idle(vecs[i].d, 48);
      check($sformatf("vec%0d bytes", i), acc[vecs[i].d] - s_acc, vecs[i].e_acc);
      check($sformatf("vec%0d frame_err", i), nfe[vecs[i].d] - s_fe, vecs[i].e_fe);
      check($sformatf("vec%0d parity_err", i), npe[vecs[i].d] - s_pe, vecs[i].e_pe);
      if (vecs[i].e_acc == 1) check($sformatf("vec%0d data", i), int'(last[vecs[i].d]), int'(vecs[i].data));
    end

    // Bad stop bit followed by a long break gives one framing error, then recovery.
    s_acc = acc[0]; s_fe = nfe[0];
    send(0, 8'h3C, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    idle(0, 48);
    check("break frame_err", nfe[0] - s_fe, 1);
    check("break no byte", acc[0] - s_acc, 0);
    s_acc = acc[0];
    send(0, 8'h81, 1'b0, 1'b1);
    idle(0, 48);
    check("after break bytes", acc[0] - s_acc, 1);
    check("after break data", int'(last[0]), 8'h81);

    // Overrun: two back-to-back frames while downstream is stalled.
    rdy[0] = 1'b0;
    s_acc = acc[0]; s_ov = nov[0];
    send(0, 8'h11, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 1'b1);
    idle(0, 32);
    check("overrun held valid", int'(vld[0]), 1);
    check("overrun held data", int'(dout[0]), 8'h11);
    check("overrun pulse", nov[0] - s_ov, 1);
    check("overrun no transfer", acc[0] - s_acc, 0);
    @(posedge clk);
    #1 rdy[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("drain transfer", acc[0] - s_acc, 1);
    check("drain data", int'(last[0]), 8'h11);
    check("drain valid low", int'(vld[0]), 0);

    // Reset in the middle of the data bits of 0x55.
    s_acc = acc[0];
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    check("pre-reset busy", int'(bsy[0]), 1);
    rst = 1'b1;
    rxl[0] = 1'b1;
    @(negedge clk);
    check("mid reset busy", int'(bsy[0]), 0);
    check("mid reset valid", int'(vld[0]), 0);
    check("mid reset data", int'(dout[0]), 0);
    check("mid reset errors", int'({fe[0], pe[0], ov[0]}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(0, 32);
    send(0, 8'h99, 1'b0, 1'b1);
    idle(0, 48);
    check("post reset bytes", acc[0] - s_acc, 1);
    check("post reset data", int'(last[0]), 8'h99);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
